// File: rtl/counter_arb_pkg.sv
// Shared opcodes and FSM state encodings for the
// arbitrated saturating counter.
package counter_arb_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or
// after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDW'(j);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin shared saturating accumulator: one command in
// flight, executed in EXEC and answered from RESP.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_x,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_err,
    output logic [WIDTH-1:0]      count,
    output logic                  sat
);

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] x_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rr_ptr;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   win;
    logic             any;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] cnt_nx;
    logic             sat_nx;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .gnt  (gnt),
        .idx  (win),
        .any  (any)
    );

    assign req_ready = (resetn && state == ST_IDLE) ? gnt : '0;

    assign sum = {1'b0, count} + {1'b0, x_q};

    always_comb begin
        cnt_nx = count;
        sat_nx = sat;
        case (op_q)
            OP_ADD: begin
                if (sum[WIDTH]) begin
                    cnt_nx = '1;
                    sat_nx = 1'b1;
                end else begin
                    cnt_nx = sum[WIDTH-1:0];
                end
            end
            OP_CLEAR: begin
                cnt_nx = '0;
                sat_nx = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            count      <= '0;
            sat        <= 1'b0;
            rr_ptr     <= '0;
            op_q       <= OP_READ;
            x_q        <= '0;
            id_q       <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any) begin
                        op_q   <= req_op[2*win +: 2];
                        x_q    <= req_x[WIDTH*win +: WIDTH];
                        id_q   <= win;
                        rr_ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    count      <= cnt_nx;
                    sat        <= sat_nx;
                    resp_data  <= cnt_nx;
                    resp_id    <= id_q;
                    resp_err   <= (op_q == OP_RSVD);
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
